// File: rtl/mem_responder.sv
// Word-addressed memory responder: instruction ROM and data RAM behind a MEM_Read/MEM_Write/MEM_MFC handshake.
// Optional MEM_RESPONDER_ROM_WP_EN makes the ROM read-only for the core; the Load_* preload port still writes it.
module mem_responder #(
    parameter int unsigned ROM_WORDS = 256,
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_Data_In,
    input  logic        MEM_Read,
    input  logic        MEM_Write,
    output logic [31:0] MEM_Data_Out,
    output logic        MEM_MFC,
    output logic        MEM_ANA_FLAG,
    input  logic        Load_En,
    input  logic [31:0] Load_Addr,
    input  logic [31:0] Load_Data,
    output logic [1:0]  debug_state
);

    // Handshake: a request level seen high in IDLE is accepted on that edge; MEM_MFC rises LATENCY
    // edges later and stays high until the core drops both request lines, then falls on the next edge.
    localparam int ROM_AW = $clog2(ROM_WORDS);
    localparam int RAM_AW = $clog2(RAM_WORDS);
`ifdef MEM_RESPONDER_ROM_WP_EN
    localparam bit ROM_WP = 1'b1;
`else
    localparam bit ROM_WP = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_data;
    logic              lat_rd;
    logic              lat_wr;
    logic [31:0]       rom [ROM_WORDS];
    logic [31:0]       ram [RAM_WORDS];
    logic              req;
    logic              rom_hit;
    logic              ram_hit;
    logic              illegal;
    logic              complete;
    logic              rom_wr;
    logic              ram_wr;
    logic [ROM_AW-1:0] rom_idx;
    logic [ROM_AW-1:0] load_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_load_bits;

    assign req      = MEM_Read | MEM_Write;
    assign rom_hit  = lat_addr < 32'(ROM_WORDS);
    assign ram_hit  = (lat_addr >= RAM_BASE) && (lat_addr < RAM_BASE + 32'(RAM_WORDS));
    assign rom_idx  = lat_addr[ROM_AW-1:0];
    // RAM_BASE is aligned to RAM_WORDS, so the low address bits are the RAM offset.
    assign ram_idx  = lat_addr[RAM_AW-1:0];
    assign load_idx = Load_Addr[ROM_AW-1:0];
    assign unused_load_bits = ^Load_Addr[31:ROM_AW];

    assign illegal  = lat_rd & lat_wr;
    assign complete = (state == S_WAIT) && req && (cnt == 4'd0);
    assign rom_wr   = complete && lat_wr && !lat_rd && rom_hit && !ROM_WP;
    assign ram_wr   = complete && lat_wr && !lat_rd && !rom_hit && ram_hit;
    assign debug_state = state;

    // Storage is never cleared; a reset forces state to IDLE so no pending write can commit.
    always_ff @(posedge Clock) begin
        if (ram_wr) begin
            ram[ram_idx] <= lat_data;
        end
        if (rom_wr) begin
            rom[rom_idx] <= lat_data;
        end
        if (Load_En) begin
            rom[load_idx] <= Load_Data;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            lat_addr     <= 32'd0;
            lat_data     <= 32'd0;
            lat_rd       <= 1'b0;
            lat_wr       <= 1'b0;
            MEM_Data_Out <= 32'd0;
            MEM_MFC      <= 1'b0;
            MEM_ANA_FLAG <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_addr <= MEM_Address;
                        lat_data <= MEM_Data_In;
                        lat_rd   <= MEM_Read;
                        lat_wr   <= MEM_Write;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        MEM_MFC <= 1'b1;
                        state   <= S_DONE;
                        if (illegal) begin
                            MEM_Data_Out <= 32'd0;
                            MEM_ANA_FLAG <= 1'b1;
                        end else if (lat_rd) begin
                            // rom[] read here sees the pre-edge word even if Load_En hits it now.
                            if (rom_hit) begin
                                MEM_Data_Out <= rom[rom_idx];
                                MEM_ANA_FLAG <= 1'b0;
                            end else if (ram_hit) begin
                                MEM_Data_Out <= ram[ram_idx];
                                MEM_ANA_FLAG <= 1'b0;
                            end else begin
                                MEM_Data_Out <= 32'd0;
                                MEM_ANA_FLAG <= 1'b1;
                            end
                        end else begin
                            MEM_ANA_FLAG <= rom_hit ? ROM_WP : !ram_hit;
                        end
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        MEM_MFC      <= 1'b0;
                        MEM_ANA_FLAG <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
